// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, clear/run FSM states and the
// clog2 helper used to size register addresses.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int REG_ZERO = 0;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: decode/issue/writeback bus of the register file.
// Ports: rd_addr/rd_data/rd_busy, wr_*, reserve_*, ready.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NUM_REGS = 32,
  parameter int NUM_READ = 2
) ();

  localparam int AW = clog2(NUM_REGS);

  logic [NUM_READ*AW-1:0]   rd_addr_i;
  logic [NUM_READ*XLEN-1:0] rd_data_o;
  logic [NUM_READ-1:0]      rd_busy_o;
  logic                     wr_enable_i;
  logic [AW-1:0]            wr_addr_i;
  logic [XLEN-1:0]          wr_data_i;
  logic                     reserve_i;
  logic [AW-1:0]            reserve_addr_i;
  logic                     ready_o;

  modport master (
    output rd_addr_i,
    input  rd_data_o,
    input  rd_busy_o,
    output wr_enable_i,
    output wr_addr_i,
    output wr_data_i,
    output reserve_i,
    output reserve_addr_i,
    input  ready_o
  );

  modport slave (
    input  rd_addr_i,
    output rd_data_o,
    output rd_busy_o,
    input  wr_enable_i,
    input  wr_addr_i,
    input  wr_data_i,
    input  reserve_i,
    input  reserve_addr_i,
    output ready_o
  );

endinterface

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read mux with write bypass
// and busy override. In: ready, addr, storage, busy, write. Out: data, busy.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NUM_REGS = 32,
  parameter int AW       = 5,
  parameter int BYPASS   = 1
) (
  input  logic                     i_ready,
  input  logic [AW-1:0]            i_addr,
  input  logic [NUM_REGS*XLEN-1:0] i_mem,
  input  logic [NUM_REGS-1:0]      i_busy,
  input  logic                     i_wr_en,
  input  logic [AW-1:0]            i_wr_addr,
  input  logic [XLEN-1:0]          i_wr_data,
  output logic [XLEN-1:0]          o_data,
  output logic                     o_busy
);

  logic w_valid;
  logic w_hit;

  // Reg 0 and addresses past the file read as zero / not busy.
  assign w_valid = i_ready
                && (i_addr != AW'(REG_ZERO))
                && (32'(i_addr) < NUM_REGS);

  // i_wr_en is already qualified by ready and a nonzero address.
  assign w_hit = (BYPASS != 0)
              && i_wr_en
              && (i_wr_addr == i_addr);

  always_comb begin
    o_data = '0;
    o_busy = 1'b0;
    if (w_valid) begin
      if (w_hit) begin
        o_data = i_wr_data;
        o_busy = 1'b0;
      end else begin
        o_data = i_mem[32'(i_addr)*XLEN +: XLEN];
        o_busy = i_busy[i_addr];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: N-read/1-write register file with busy scoreboard,
// bypass and reset sweep. Ports: clk, reset, bus (regfile_mp_if.slave).
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN           = XLEN_DEF,
  parameter int NUM_REGS       = 32,
  parameter int NUM_READ       = 2,
  parameter int BYPASS         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic        clk,
  input logic        reset,
  regfile_mp_if.slave bus
);

  localparam int AW = clog2(NUM_REGS);

  rf_state_e                r_state;
  rf_state_e                w_state_nxt;
  logic [AW-1:0]            r_clr_ptr;
  logic [AW-1:0]            w_clr_ptr_nxt;
  logic                     w_clr_we;
  logic                     w_ready;
  logic                     w_wr_ok;
  logic                     w_rsv_ok;
  logic [XLEN-1:0]          r_mem [NUM_REGS];
  logic [NUM_REGS-1:0]      r_busy;
  logic [NUM_REGS*XLEN-1:0] w_mem_flat;
  logic [NUM_READ*XLEN-1:0] w_rd_data;
  logic [NUM_READ-1:0]      w_rd_busy;

  assign w_ready     = (r_state == RUN);
  assign bus.ready_o = w_ready;

  assign w_wr_ok = w_ready
                && bus.wr_enable_i
                && (bus.wr_addr_i != AW'(REG_ZERO))
                && (32'(bus.wr_addr_i) < NUM_REGS);

  assign w_rsv_ok = w_ready
                 && bus.reserve_i
                 && (bus.reserve_addr_i != AW'(REG_ZERO))
                 && (32'(bus.reserve_addr_i) < NUM_REGS);

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    w_clr_we      = 1'b0;
    unique case (r_state)
      CLEAR: begin
        if (CLEAR_ON_RESET != 0) begin
          w_clr_we = 1'b1;
          if (32'(r_clr_ptr) == NUM_REGS - 1) begin
            w_state_nxt = RUN;
          end else begin
            w_clr_ptr_nxt = r_clr_ptr + 1'b1;
          end
        end else begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  // Release before reserve so a same-cycle reserve keeps busy set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= CLEAR;
      r_clr_ptr <= '0;
      r_busy    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
      if (w_wr_ok) begin
        r_busy[bus.wr_addr_i] <= 1'b0;
      end
      if (w_rsv_ok) begin
        r_busy[bus.reserve_addr_i] <= 1'b1;
      end
    end
  end

  // Sweep and writeback are exclusive: one runs in CLEAR, one in RUN.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_clr_we) begin
        r_mem[r_clr_ptr] <= '0;
      end else if (w_wr_ok) begin
        r_mem[bus.wr_addr_i] <= bus.wr_data_i;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign w_mem_flat[g*XLEN +: XLEN] = r_mem[g];
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    regfile_read_port #(
      .XLEN     (XLEN),
      .NUM_REGS (NUM_REGS),
      .AW       (AW),
      .BYPASS   (BYPASS)
    ) u_port (
      .i_ready   (w_ready),
      .i_addr    (bus.rd_addr_i[k*AW +: AW]),
      .i_mem     (w_mem_flat),
      .i_busy    (r_busy),
      .i_wr_en   (w_wr_ok),
      .i_wr_addr (bus.wr_addr_i),
      .i_wr_data (bus.wr_data_i),
      .o_data    (w_rd_data[k*XLEN +: XLEN]),
      .o_busy    (w_rd_busy[k])
    );
  end

  assign bus.rd_data_o = w_rd_data;
  assign bus.rd_busy_o = w_rd_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: bypass, no-bypass and no-sweep instances on one
// shared stimulus stream, checked against a spec-level model.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int NR = 32;
  localparam int NP = 4;
  localparam int XL = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(XL), .NUM_REGS(NR), .NUM_READ(NP))
    ifa (), ifb (), ifc ();

  assign ifb.rd_addr_i      = ifa.rd_addr_i;
  assign ifb.wr_enable_i    = ifa.wr_enable_i;
  assign ifb.wr_addr_i      = ifa.wr_addr_i;
  assign ifb.wr_data_i      = ifa.wr_data_i;
  assign ifb.reserve_i      = ifa.reserve_i;
  assign ifb.reserve_addr_i = ifa.reserve_addr_i;
  assign ifc.rd_addr_i      = ifa.rd_addr_i;
  assign ifc.wr_enable_i    = ifa.wr_enable_i;
  assign ifc.wr_addr_i      = ifa.wr_addr_i;
  assign ifc.wr_data_i      = ifa.wr_data_i;
  assign ifc.reserve_i      = ifa.reserve_i;
  assign ifc.reserve_addr_i = ifa.reserve_addr_i;

  regfile_mp #(.XLEN(XL), .NUM_REGS(NR), .NUM_READ(NP),
    .BYPASS(1), .CLEAR_ON_RESET(1))
    u_a (.clk(clk), .reset(reset), .bus(ifa));
  regfile_mp #(.XLEN(XL), .NUM_REGS(NR), .NUM_READ(NP),
    .BYPASS(0), .CLEAR_ON_RESET(1))
    u_b (.clk(clk), .reset(reset), .bus(ifb));
  regfile_mp #(.XLEN(XL), .NUM_REGS(NR), .NUM_READ(NP),
    .BYPASS(1), .CLEAR_ON_RESET(0))
    u_c (.clk(clk), .reset(reset), .bus(ifc));

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] m_mem [NR];
  bit          m_busy [NR];
  int          m_since = 0;
  bit          m_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input int a, input bit byp);
    if (m_since < NR || a == 0) return 32'h0;
    if (byp && ifa.wr_enable_i && int'(ifa.wr_addr_i) == a)
      return ifa.wr_data_i;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input int a, input bit byp);
    if (m_since < NR || a == 0) return 1'b0;
    if (byp && ifa.wr_enable_i && int'(ifa.wr_addr_i) == a)
      return 1'b0;
    return m_busy[a];
  endfunction

  task automatic check_all();
    int a;
    if (!m_valid) return;
    chk("ready_a", 32'(ifa.ready_o), 32'(m_since >= NR));
    chk("ready_b", 32'(ifb.ready_o), 32'(m_since >= NR));
    chk("ready_c", 32'(ifc.ready_o), 32'(m_since >= 1));
    for (int k = 0; k < NP; k++) begin
      a = int'(ifa.rd_addr_i[k*AW +: AW]);
      chk($sformatf("data_a%0d_r%0d", k, a),
          ifa.rd_data_o[k*XL +: XL], exp_data(a, 1'b1));
      chk($sformatf("data_b%0d_r%0d", k, a),
          ifb.rd_data_o[k*XL +: XL], exp_data(a, 1'b0));
      chk($sformatf("busy_a%0d_r%0d", k, a),
          32'(ifa.rd_busy_o[k]), 32'(exp_busy(a, 1'b1)));
      chk($sformatf("busy_b%0d_r%0d", k, a),
          32'(ifb.rd_busy_o[k]), 32'(exp_busy(a, 1'b0)));
    end
  endtask

  task automatic model_edge();
    int wa;
    int ra;
    wa = int'(ifa.wr_addr_i);
    ra = int'(ifa.reserve_addr_i);
    if (reset) begin
      m_valid = 1'b1;
      m_since = 0;
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      return;
    end
    if (!m_valid) return;
    if (m_since >= NR) begin
      if (ifa.wr_enable_i && wa != 0) begin
        m_mem[wa] = ifa.wr_data_i;
        m_busy[wa] = 1'b0;
      end
      if (ifa.reserve_i && ra != 0) m_busy[ra] = 1'b1;
    end else begin
      m_since++;
      if (m_since == NR) foreach (m_mem[i]) m_mem[i] = 32'h0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    ifa.wr_enable_i = 1'b0;
    ifa.reserve_i   = 1'b0;
  endtask

  task automatic rand_rd();
    for (int k = 0; k < NP; k++)
      ifa.rd_addr_i[k*AW +: AW] = AW'($urandom_range(0, NR - 1));
  endtask

  task automatic rand_all();
    rand_rd();
    ifa.wr_enable_i    = 1'($urandom_range(0, 1));
    ifa.wr_addr_i      = AW'($urandom_range(0, NR - 1));
    ifa.wr_data_i      = $urandom;
    ifa.reserve_i      = 1'($urandom_range(0, 1));
    ifa.reserve_addr_i = AW'($urandom_range(0, NR - 1));
  endtask

  task automatic wait_ready(input string tag, input bool_rand);
    int n;
    n = 0;
    while (ifa.ready_o !== 1'b1 && n < 100) begin
      if (bool_rand) rand_all();
      tick();
      n++;
    end
    chk(tag, 32'(n), 32'(NR));
    idle();
  endtask

  initial begin
    ifa.rd_addr_i      = '0;
    ifa.wr_enable_i    = 1'b0;
    ifa.wr_addr_i      = '0;
    ifa.wr_data_i      = '0;
    ifa.reserve_i      = 1'b0;
    ifa.reserve_addr_i = '0;

    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    wait_ready("clear_len_first", 1'b0);

    for (int a = 1; a < NR; a++) begin
      ifa.wr_enable_i = 1'b1;
      ifa.wr_addr_i   = AW'(a);
      ifa.wr_data_i   = $urandom;
      rand_rd();
      tick();
    end
    idle();
    for (int a = 0; a < NR; a += NP) begin
      for (int k = 0; k < NP; k++)
        ifa.rd_addr_i[k*AW +: AW] = AW'(a + k);
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      rand_rd();
      tick();
    end

    ifa.wr_enable_i = 1'b1;
    ifa.wr_addr_i   = '0;
    ifa.wr_data_i   = 32'hFFFF_FFFF;
    ifa.rd_addr_i   = '0;
    tick();
    idle();
    #1;
    chk("reg0_zero", ifa.rd_data_o[0 +: XL], 32'h0);
    tick();

    ifa.wr_enable_i = 1'b1;
    ifa.wr_addr_i   = AW'(7);
    ifa.wr_data_i   = 32'h1234_5678;
    ifa.rd_addr_i[0 +: AW] = AW'(7);
    #1;
    chk("bypass_a", ifa.rd_data_o[0 +: XL], 32'h1234_5678);
    tick();
    idle();
    #1;
    chk("nobypass_b_next", ifb.rd_data_o[0 +: XL], 32'h1234_5678);
    tick();

    ifa.reserve_i      = 1'b1;
    ifa.reserve_addr_i = AW'(9);
    ifa.rd_addr_i[0 +: AW] = AW'(9);
    tick();
    idle();
    #1;
    chk("rsv9_busy", 32'(ifa.rd_busy_o[0]), 32'h1);
    tick();
    ifa.wr_enable_i = 1'b1;
    ifa.wr_addr_i   = AW'(9);
    ifa.wr_data_i   = $urandom;
    #1;
    chk("wr9_busy_a", 32'(ifa.rd_busy_o[0]), 32'h0);
    chk("wr9_busy_b", 32'(ifb.rd_busy_o[0]), 32'h1);
    tick();
    idle();
    #1;
    chk("wr9_busy_b_next", 32'(ifb.rd_busy_o[0]), 32'h0);
    ifa.reserve_i      = 1'b1;
    ifa.reserve_addr_i = '0;
    ifa.rd_addr_i[0 +: AW] = '0;
    tick();
    idle();
    #1;
    chk("rsv0_busy", 32'(ifa.rd_busy_o[0]), 32'h0);
    tick();

    ifa.wr_enable_i    = 1'b1;
    ifa.wr_addr_i      = AW'(3);
    ifa.wr_data_i      = 32'hA5A5_0003;
    ifa.reserve_i      = 1'b1;
    ifa.reserve_addr_i = AW'(3);
    ifa.rd_addr_i[0 +: AW] = AW'(3);
    tick();
    idle();
    #1;
    chk("wr_rsv3_data", ifb.rd_data_o[0 +: XL], 32'hA5A5_0003);
    chk("wr_rsv3_busy", 32'(ifb.rd_busy_o[0]), 32'h1);
    tick();

    for (int i = 0; i < 300; i++) begin
      rand_all();
      tick();
    end

    ifa.wr_enable_i = 1'b1;
    ifa.wr_addr_i   = AW'(5);
    ifa.wr_data_i   = 32'hDEAD_BEEF;
    tick();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_ready("clear_len_pulse", 1'b0);
    ifa.rd_addr_i[0 +: AW] = AW'(5);
    #1;
    chk("reg5_cleared", ifa.rd_data_o[0 +: XL], 32'h0);
    tick();

    for (int i = 0; i < 50; i++) begin
      rand_all();
      tick();
    end
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rand_all();
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_ready("clear_len_restart", 1'b1);
    for (int a = 1; a < NR; a++) begin
      ifa.rd_addr_i[0 +: AW] = AW'(a);
      #1;
      chk($sformatf("swept_r%0d", a), ifa.rd_data_o[0 +: XL], 32'h0);
      chk($sformatf("swept_busy_r%0d", a),
          32'(ifa.rd_busy_o[0]), 32'h0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-read-port register file, successor to the core's 2R1W integer register file. Adds N read ports, optional write-to-read bypass, a per-register busy scoreboard for in-flight producers, and a reset-time sequential clear FSM. Sits in the decode/issue stage: decode reads operands and busy bits, issue reserves the destination, writeback writes and releases it.

Parameters:
XLEN, 32, data width in bits
NUM_REGS, 32, number of architectural registers (>=2); register 0 hardwired to zero
NUM_READ, 2, number of read ports (1..8)
BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports and busy bits
CLEAR_ON_RESET, 1, 1 = sweep all registers to zero after reset; 0 = skip the sweep
AW (localparam), clog2(NUM_REGS), register address width

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
rd_addr_i  in  NUM_READ*AW  packed read addresses; port k at bits [k*AW +: AW]
rd_data_o  out  NUM_READ*XLEN  packed read data, combinational
rd_busy_o  out  NUM_READ  busy bit of each addressed register, combinational
wr_enable_i  in  1  writeback enable
wr_addr_i  in  AW  writeback address
wr_data_i  in  XLEN  writeback data
reserve_i  in  1  mark a destination busy (issue)
reserve_addr_i  in  AW  destination to reserve
ready_o  out  1  1 = RUN state; writes, reserves and reads are valid

Behaviour:
- Decided interface: one clock, clk; reset is synchronous and active-high.
- FSM states: CLEAR, RUN. Reset edge -> CLEAR, clr_ptr=0, all busy bits=0, ready_o=0.
- CLEAR (CLEAR_ON_RESET=1): each cycle writes 0 to reg[clr_ptr] and increments. After reg NUM_REGS-1 is cleared -> RUN. ready_o rises exactly NUM_REGS cycles after the first non-reset edge.
- CLEAR_ON_RESET=0: CLEAR lasts one cycle; register contents are undefined except reg0=0.
- Reset asserted mid-CLEAR or mid-RUN: restart CLEAR at ptr 0 and clear all busy bits.
- While ready_o=0: wr_enable_i and reserve_i ignored; rd_data_o=0 and rd_busy_o=0 on all ports.
- RUN write: wr_enable_i=1 and wr_addr_i!=0 -> reg[wr_addr_i]<=wr_data_i at the edge. Writes to 0 are dropped.
- Read: rd_data_o[k]=reg[addr_k]. Address 0 or address >=NUM_REGS returns 0.
- Bypass (BYPASS=1): if wr_enable_i, wr_addr_i==addr_k and addr_k!=0, then rd_data_o[k]=wr_data_i in the same cycle. With BYPASS=0, new data is visible the cycle after the write.
- Scoreboard: a write releases busy[wr_addr_i] at the edge; reserve_i sets busy[reserve_addr_i] at the edge.
  - Same address for write and reserve in one cycle: reserve wins, busy stays 1.
  - Reserve of reg 0 is ignored; busy[0] is always 0.
- rd_busy_o[k]=busy[addr_k], except with BYPASS=1 a same-cycle write to addr_k forces 0.
- Any number of read ports may hit the same address, and all return identical data.
- No output registers: read latency is 0 cycles, write-to-read latency is 1 cycle (0 with bypass).

Decomposition:
- Shared package regfile_pkg: XLEN default, register-0 constant, FSM state enum {CLEAR, RUN}, and the clog2 helper function.
- One sub-module, regfile_read_port: one combinational read mux with bypass and busy override, instantiated NUM_READ times in a generate loop.
- Storage, scoreboard and FSM live in the top module.

Test Plan:
- Reset clear: write 0xDEADBEEF to reg 5, pulse reset for 1 cycle. Then:
  - ready_o=0 for exactly 32 cycles;
  - reading reg 5 after ready_o=1 returns 0x00000000.
- Write/readback across 4 ports (NUM_READ=4): write $random to regs 1..31, read 4 addresses per cycle -> every value matches; reg 0 reads 0 after writing 0xFFFFFFFF to it.
- Bypass: in the same cycle, write 0x12345678 to reg 7 with port0=7 -> rd_data_o[0]=0x12345678 that cycle. With BYPASS=0, the old value appears that cycle and the new value the next.
- Scoreboard:
  - reserve reg 9 -> rd_busy_o=1 from the next cycle;
  - write reg 9 -> busy 0 the following cycle (same cycle with bypass);
  - reserve reg 0 -> busy stays 0.
- Simultaneous write and reserve on reg 3 -> data updated and busy stays 1.
- Reset mid-clear: assert reset at clr_ptr=10 -> sweep restarts, ready_o rises 32 cycles after deassertion, and writes during CLEAR are ignored.
